noc_packetizer: RTL



---
 rtl/noc_params.sv | 62 ++++++
 rtl/noc_credit_counter.sv | 32 +++
 rtl/noc_packetizer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared NoC flit types, sizes and flit builders
package noc_params;
    localparam int VC_NUM            = 2;
    localparam int VC_DEPTH          = 4;
    localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DEST_ADDR_SIZE_X  = 2;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int HEAD_PAYLOAD_SIZE = 58;
    localparam int BODY_PAYLOAD_SIZE = 62;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                   head_data;
        logic [BODY_PAYLOAD_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t flit_label;
        flit_data_t  data;
    } flit_t;

    typedef enum logic [0:0] {
        PK_IDLE = 1'b0,
        PK_BODY = 1'b1
    } pktzr_state_t;

    function automatic flit_t make_head_flit(
        input logic [DEST_ADDR_SIZE_X-1:0]  x,
        input logic [DEST_ADDR_SIZE_Y-1:0]  y,
        input logic [HEAD_PAYLOAD_SIZE-1:0] pl,
        input logic                         is_tail
    );
        flit_t f;
        f.flit_label             = is_tail ? HEADTAIL : HEAD;
        f.data.head_data.x_dest  = x;
        f.data.head_data.y_dest  = y;
        f.data.head_data.head_pl = pl;
        return f;
    endfunction

    function automatic flit_t make_body_flit(
        input logic [BODY_PAYLOAD_SIZE-1:0] pl,
        input logic                         is_tail
    );
        flit_t f;
        f.flit_label = is_tail ? TAIL : BODY;
        f.data.bt_pl = pl;
        return f;
    endfunction
endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - per-VC credit counter with saturation
module noc_credit_counter #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc_i,
    input  logic                         dec_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         nonzero_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0] r_count;

    // Simultaneous send and return cancel out; a surplus return saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= CW'(DEPTH);
        end else if (inc_i && !dec_i) begin
            if (r_count != CW'(DEPTH)) r_count <= r_count + 1'b1;
        end else if (dec_i && !inc_i && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count_o   = r_count;
    assign nonzero_o = (r_count != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc_i && !dec_i && r_count == CW'(DEPTH)));
endmodule

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - local-port flit transmitter with per-VC credit flow control
module noc_packetizer
    import noc_params::*;
#(
    parameter int MAX_PKT_FLITS = 8,
    parameter int VC_NUM        = noc_params::VC_NUM,
    parameter int VC_DEPTH      = noc_params::VC_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 pkt_valid_i,
    output logic                                 pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]          pkt_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]          pkt_y_dest_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0]         pkt_head_pl_i,
    input  logic [$clog2(MAX_PKT_FLITS+1)-1:0]   pkt_len_i,
    input  logic                                 pl_valid_i,
    output logic                                 pl_ready_o,
    input  logic [BODY_PAYLOAD_SIZE-1:0]         pl_data_i,
    output logic                                 flit_valid_o,
    output flit_t                                flit_o,
    output logic [VC_SIZE-1:0]                   vc_o,
    input  logic                                 credit_valid_i,
    input  logic [VC_SIZE-1:0]                   credit_vc_i,
    output logic                                 busy_o
);
    localparam int LEN_W = $clog2(MAX_PKT_FLITS+1);
    localparam int CW    = $clog2(VC_DEPTH+1);

    pktzr_state_t       r_state;
    logic               r_flit_valid;
    flit_t              r_flit;
    logic [VC_SIZE-1:0] r_vc;
    logic [VC_SIZE-1:0] r_rr_ptr;
    logic [LEN_W-1:0]   r_rem;

    logic [VC_NUM-1:0]  w_nonzero;
    logic [CW-1:0]      w_credit [VC_NUM];
    logic [VC_NUM-1:0]  w_inc;
    logic [VC_NUM-1:0]  w_dec;
    logic               w_any;
    logic [VC_SIZE-1:0] w_sel;
    logic [VC_SIZE-1:0] w_rr_next;
    logic [VC_SIZE-1:0] w_send_vc;
    logic [LEN_W-1:0]   w_len_eff;
    logic               w_pkt_acc;
    logic               w_pl_acc;
    logic               w_send;

    always_comb begin
        w_len_eff = pkt_len_i;
        if (pkt_len_i == '0)
            w_len_eff = LEN_W'(1);
        else if (pkt_len_i > LEN_W'(MAX_PKT_FLITS))
            w_len_eff = LEN_W'(MAX_PKT_FLITS);
    end

    // Walk downward so the eligible VC closest to rr_ptr is assigned last.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_rr_ptr;
        for (int i = VC_NUM-1; i >= 0; i--) begin
            if (w_nonzero[(int'(r_rr_ptr) + i) % VC_NUM]) begin
                w_any = 1'b1;
                w_sel = VC_SIZE'((int'(r_rr_ptr) + i) % VC_NUM);
            end
        end
    end

    assign w_rr_next = (w_sel == VC_SIZE'(VC_NUM-1)) ? '0 : w_sel + 1'b1;
    assign w_pkt_acc = (r_state == PK_IDLE) && pkt_valid_i && w_any;
    assign w_pl_acc  = (r_state == PK_BODY) && pl_valid_i && w_nonzero[r_vc];
    assign w_send    = w_pkt_acc || w_pl_acc;
    assign w_send_vc = (r_state == PK_IDLE) ? w_sel : r_vc;

    generate
        for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
            assign w_dec[v] = w_send && (w_send_vc == VC_SIZE'(v));
            assign w_inc[v] = credit_valid_i && (credit_vc_i == VC_SIZE'(v));
            noc_credit_counter #(.DEPTH(VC_DEPTH)) u_cc (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc_i     (w_inc[v]),
                .dec_i     (w_dec[v]),
                .count_o   (w_credit[v]),
                .nonzero_o (w_nonzero[v])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PK_IDLE;
            r_flit_valid <= 1'b0;
            r_flit       <= '0;
            r_vc         <= '0;
            r_rr_ptr     <= '0;
            r_rem        <= '0;
        end else begin
            r_flit_valid <= w_send;
            if (w_pkt_acc) begin
                r_flit   <= make_head_flit(pkt_x_dest_i, pkt_y_dest_i, pkt_head_pl_i,
                                           w_len_eff == LEN_W'(1));
                r_vc     <= w_sel;
                r_rr_ptr <= w_rr_next;
                if (w_len_eff > LEN_W'(1)) begin
                    r_state <= PK_BODY;
                    r_rem   <= w_len_eff - LEN_W'(1);
                end
            end else if (w_pl_acc) begin
                r_flit <= make_body_flit(pl_data_i, r_rem == LEN_W'(1));
                r_rem  <= r_rem - LEN_W'(1);
                if (r_rem == LEN_W'(1)) r_state <= PK_IDLE;
            end
        end
    end

    assign pkt_ready_o  = w_pkt_acc;
    assign pl_ready_o   = w_pl_acc;
    assign flit_valid_o = r_flit_valid;
    assign flit_o       = r_flit;
    assign vc_o         = r_vc;
    assign busy_o       = (r_state != PK_IDLE);

    a_len_range: assert property (@(posedge clk) disable iff (!rst_n)
        pkt_valid_i |-> pkt_len_i <= LEN_W'(MAX_PKT_FLITS));
    a_send_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
        w_send |-> w_credit[w_send_vc] != '0);
endmodule
